// File: rtl/cpu_trace_buffer_if.sv
// cpu_trace_buffer_if: commit bus and oldest-first read port of the trace buffer
interface cpu_trace_buffer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    localparam int ENTRY_W = ADDR_W + 8 + DATA_W;
    logic              commit_valid;
    logic [ADDR_W-1:0] commit_pc;
    logic [3:0]        commit_op;
    logic [3:0]        commit_rd;
    logic [DATA_W-1:0] commit_data;
    logic              rd_ready;
    logic              rd_valid;
    logic [ENTRY_W-1:0] rd_entry;
    modport master (
        output commit_valid, commit_pc, commit_op, commit_rd, commit_data, rd_ready,
        input  rd_valid, rd_entry
    );
    modport slave (
        input  commit_valid, commit_pc, commit_op, commit_rd, commit_data, rd_ready,
        output rd_valid, rd_entry
    );
endinterface

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: circular commit-trace capture with PC/opcode trigger and oldest-first drain
module cpu_trace_buffer #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int DEPTH     = 8,
    parameter int POST_TRIG = 2,
    localparam int PW       = $clog2(DEPTH),
    localparam int CW       = PW + 1,
    localparam int ENTRY_W  = ADDR_W + 8 + DATA_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              arm_i,
    input  logic              trig_mode_i,
    input  logic [ADDR_W-1:0] trig_pc_i,
    input  logic [3:0]        trig_op_i,
    cpu_trace_buffer_if.slave bus,
    output logic [1:0]        state_o,
    output logic [CW-1:0]     count_o,
    output logic              triggered_o,
    output logic              overflow_o
);
    typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       count_q, count_d, post_q, post_d;
    logic [PW-1:0]       wptr_q, wptr_d, rptr;
    logic                trig_q, trig_d, ovf_q, ovf_d;
    logic                wr_en, hit, full, rd_valid;
    logic [ENTRY_W-1:0]  mem_q [DEPTH];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            count_q <= '0;
            post_q  <= '0;
            wptr_q  <= '0;
            trig_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            post_q  <= post_d;
            wptr_q  <= wptr_d;
            trig_q  <= trig_d;
            ovf_q   <= ovf_d;
        end
    end

    // storage is deliberately left out of reset
    always_ff @(posedge CLK)
        if (wr_en) mem_q[wptr_q] <= {bus.commit_pc, bus.commit_op, bus.commit_rd, bus.commit_data};

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        post_d  = post_q;
        wptr_d  = wptr_q;
        trig_d  = trig_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;
        full    = count_q == CW'(DEPTH);
        hit     = trig_mode_i ? bus.commit_op == trig_op_i : bus.commit_pc == trig_pc_i;
        if (arm_i) begin
            state_d = ARMED;
            count_d = '0;
            wptr_d  = '0;
            trig_d  = 1'b0;
            ovf_d   = 1'b0;
        end else if ((state_q == ARMED || state_q == POST) && bus.commit_valid) begin
            wr_en   = 1'b1;
            wptr_d  = wptr_q + 1'b1;
            count_d = full ? count_q : count_q + 1'b1;
            ovf_d   = ovf_q | full;
            if (state_q == ARMED && hit) begin
                trig_d  = 1'b1;
                state_d = POST_TRIG == 0 ? DONE : POST;
                post_d  = CW'(POST_TRIG);
            end else if (state_q == POST) begin
                post_d  = post_q - 1'b1;
                state_d = post_q == CW'(1) ? DONE : POST;
            end
        end else if (rd_valid && bus.rd_ready) begin
            count_d = count_q - 1'b1;
        end
    end

    // a full buffer has its oldest entry at wptr, which the truncated subtraction yields
    always_comb begin
        rptr         = wptr_q - count_q[PW-1:0];
        rd_valid     = state_q == DONE && count_q != '0;
        bus.rd_valid = rd_valid;
        bus.rd_entry = rd_valid ? mem_q[rptr] : '0;
        state_o      = state_q;
        count_o      = count_q;
        triggered_o  = trig_q;
        overflow_o   = ovf_q;
    end
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb_cpu_trace_buffer: directed stimulus on two buffers (POST_TRIG 2 and 0) against a queue model
module tb_cpu_trace_buffer;
    localparam int EW = 40;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    logic arm = 1'b0, tmode = 1'b0, cv = 1'b0;
    logic [15:0] tpc = '0, cpc = '0, cdat = '0;
    logic [3:0]  top = '0, cop = '0, crd = '0;
    logic [1:0]  rdy = '0;
    logic [1:0][1:0] st;
    logic [1:0][3:0] cnt;
    logic [1:0] tg, ov, rv;
    logic [1:0][EW-1:0] re;

    int checks = 0, errors = 0;
    int ms[2];
    int mp[2];
    bit mt[2], mo[2];
    logic [EW-1:0] mq[2][$];
    int pt[2] = '{2, 0};
    logic [EW-1:0] rd_log[$];

    always #5 CLK = ~CLK;

    cpu_trace_buffer_if bus0();
    cpu_trace_buffer_if bus1();

    assign bus0.commit_valid = cv;
    assign bus0.commit_pc    = cpc;
    assign bus0.commit_op    = cop;
    assign bus0.commit_rd    = crd;
    assign bus0.commit_data  = cdat;
    assign bus0.rd_ready     = rdy[0];
    assign bus1.commit_valid = cv;
    assign bus1.commit_pc    = cpc;
    assign bus1.commit_op    = cop;
    assign bus1.commit_rd    = crd;
    assign bus1.commit_data  = cdat;
    assign bus1.rd_ready     = rdy[1];
    assign rv = {bus1.rd_valid, bus0.rd_valid};
    assign re = {bus1.rd_entry, bus0.rd_entry};

    cpu_trace_buffer #(.POST_TRIG(2)) u_dut0 (
        .CLK(CLK), .RESET(RESET), .arm_i(arm), .trig_mode_i(tmode), .trig_pc_i(tpc),
        .trig_op_i(top), .bus(bus0.slave), .state_o(st[0]), .count_o(cnt[0]),
        .triggered_o(tg[0]), .overflow_o(ov[0]));

    cpu_trace_buffer #(.POST_TRIG(0)) u_dut1 (
        .CLK(CLK), .RESET(RESET), .arm_i(arm), .trig_mode_i(tmode), .trig_pc_i(tpc),
        .trig_op_i(top), .bus(bus1.slave), .state_o(st[1]), .count_o(cnt[1]),
        .triggered_o(tg[1]), .overflow_o(ov[1]));

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] opf(input logic [15:0] pc);
        return pc[3:0] ^ 4'h5;
    endfunction

    function automatic logic [EW-1:0] mk(input logic [15:0] pc, input logic [3:0] op);
        return {pc, op, ~pc[3:0], 16'hA000 | pc};
    endfunction

    // Model: a trace is a list of commits bounded at DEPTH, newest at the back
    initial forever begin
        @(posedge CLK or negedge RESET);
        for (int k = 0; k < 2; k++) begin
            if (!RESET) begin
                ms[k] = 0; mq[k].delete(); mt[k] = 0; mo[k] = 0; mp[k] = 0;
            end else if (arm) begin
                ms[k] = 1; mq[k].delete(); mt[k] = 0; mo[k] = 0;
            end else if ((ms[k] == 1 || ms[k] == 2) && cv) begin
                mq[k].push_back({cpc, cop, crd, cdat});
                if (mq[k].size() > 8) begin
                    void'(mq[k].pop_front());
                    mo[k] = 1;
                end
                if (ms[k] == 1) begin
                    if (tmode ? cop == top : cpc == tpc) begin
                        mt[k] = 1;
                        mp[k] = pt[k];
                        ms[k] = pt[k] == 0 ? 3 : 2;
                    end
                end else begin
                    mp[k]--;
                    if (mp[k] == 0) ms[k] = 3;
                end
            end else if (ms[k] == 3 && mq[k].size() > 0 && rdy[k]) begin
                void'(mq[k].pop_front());
            end
        end
    end

    always @(negedge CLK) begin
        if (RESET) begin
            for (int k = 0; k < 2; k++) begin
                logic ev;
                ev = ms[k] == 3 && mq[k].size() > 0;
                chk($sformatf("m_state%0d", k), 64'(st[k]), 64'(ms[k]));
                chk($sformatf("m_count%0d", k), 64'(cnt[k]), 64'(mq[k].size()));
                chk($sformatf("m_trig%0d", k), 64'(tg[k]), 64'(mt[k]));
                chk($sformatf("m_ovf%0d", k), 64'(ov[k]), 64'(mo[k]));
                chk($sformatf("m_rdv%0d", k), 64'(rv[k]), 64'(ev));
                chk($sformatf("m_entry%0d", k), 64'(re[k]), ev ? 64'(mq[k][0]) : 64'(0));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic commit(input logic [15:0] pc, input logic [3:0] op);
        cv = 1'b1; cpc = pc; cop = op; crd = ~pc[3:0]; cdat = 16'hA000 | pc;
        tick();
        cv = 1'b0;
    endtask

    task automatic drain(input int k, input bit toggle);
        rd_log.delete();
        for (int c = 0; c < 64 && rv[k]; c++) begin
            rdy[k] = toggle ? ~c[0] : 1'b1;
            if (rv[k] && rdy[k]) rd_log.push_back(re[k]);
            tick();
        end
        rdy[k] = 1'b0;
        chk("drain_done_valid", 64'(rv[k]), 64'(0));
        chk("drain_done_entry", 64'(re[k]), 64'(0));
    endtask

    initial begin
        tick();
        chk("rst_state", 64'(st[0]), 64'(0));
        chk("rst_count", 64'(cnt[0]), 64'(0));
        chk("rst_rdv", 64'(rv[0]), 64'(0));
        chk("rst_entry", 64'(re[0]), 64'(0));
        RESET = 1'b1;
        tick();

        // 1: asynchronous reset in the middle of a capture
        tpc = 16'd100;
        do_arm();
        for (int i = 0; i < 3; i++) commit(16'(i), opf(16'(i)));
        chk("t1_count_pre", 64'(cnt[0]), 64'(3));
        #2 RESET = 1'b0;
        #1;
        chk("t1_state", 64'(st[0]), 64'(0));
        chk("t1_count", 64'(cnt[0]), 64'(0));
        chk("t1_rdv", 64'(rv[0]), 64'(0));
        tick();
        RESET = 1'b1;
        commit(16'd7, opf(16'd7));
        chk("t1_idle_state", 64'(st[0]), 64'(0));
        chk("t1_idle_count", 64'(cnt[0]), 64'(0));

        // 2: PC trigger
        tmode = 1'b0; tpc = 16'd3;
        do_arm();
        for (int i = 0; i < 6; i++) commit(16'(i), opf(16'(i)));
        chk("t2_state", 64'(st[0]), 64'(3));
        chk("t2_count", 64'(cnt[0]), 64'(6));
        chk("t2_trig", 64'(tg[0]), 64'(1));
        chk("t2_ovf", 64'(ov[0]), 64'(0));
        commit(16'd6, opf(16'd6));
        chk("t2_frozen", 64'(cnt[0]), 64'(6));
        drain(0, 1'b0);
        chk("t2_nreads", 64'(rd_log.size()), 64'(6));
        foreach (rd_log[i]) chk($sformatf("t2_pc%0d", i), 64'(rd_log[i][39:24]), 64'(i));

        // 3: wrap with overflow
        tpc = 16'd12;
        do_arm();
        for (int i = 0; i < 15; i++) commit(16'(i), opf(16'(i)));
        chk("t3_count", 64'(cnt[0]), 64'(8));
        chk("t3_ovf", 64'(ov[0]), 64'(1));
        chk("t3_first", 64'(re[0]), 64'(40'h07_2_8_A007));
        drain(0, 1'b0);
        chk("t3_nreads", 64'(rd_log.size()), 64'(8));
        foreach (rd_log[i]) chk($sformatf("t3_entry%0d", i), 64'(rd_log[i]), 64'(mk(16'(7 + i), opf(16'(7 + i)))));

        // 4: opcode trigger with no post-trigger window
        tmode = 1'b1; top = 4'hF;
        do_arm();
        commit(16'd0, 4'h1);
        commit(16'd1, 4'h2);
        chk("t4_not_yet", 64'(st[1]), 64'(1));
        commit(16'd2, 4'hF);
        chk("t4_state", 64'(st[1]), 64'(3));
        chk("t4_count", 64'(cnt[1]), 64'(3));
        drain(1, 1'b0);
        chk("t4_nreads", 64'(rd_log.size()), 64'(3));
        if (rd_log.size() == 3) chk("t4_last_op", 64'(rd_log[2][23:20]), 64'(4'hF));

        // 5: backpressure then alternating ready
        tmode = 1'b0; tpc = 16'd2;
        do_arm();
        for (int i = 0; i < 5; i++) commit(16'(i), opf(16'(i)));
        for (int i = 0; i < 5; i++) begin
            rdy[0] = 1'b0;
            tick();
            chk("t5_hold_entry", 64'(re[0]), 64'(mk(16'd0, opf(16'd0))));
            chk("t5_hold_count", 64'(cnt[0]), 64'(5));
        end
        drain(0, 1'b1);
        chk("t5_nreads", 64'(rd_log.size()), 64'(5));
        foreach (rd_log[i]) chk($sformatf("t5_pc%0d", i), 64'(rd_log[i][39:24]), 64'(i));

        // 6: re-arm in DONE with unread entries and a same-cycle commit
        tpc = 16'd3;
        do_arm();
        for (int i = 0; i < 6; i++) commit(16'(i), opf(16'(i)));
        chk("t6_pre_state", 64'(st[1]), 64'(3));
        chk("t6_pre_count", 64'(cnt[1]), 64'(4));
        arm = 1'b1; cv = 1'b1; cpc = 16'd9; cop = opf(16'd9);
        tick();
        arm = 1'b0; cv = 1'b0;
        chk("t6_state", 64'(st[1]), 64'(1));
        chk("t6_count", 64'(cnt[1]), 64'(0));
        chk("t6_rdv", 64'(rv[1]), 64'(0));
        tick();
        chk("t6_dropped", 64'(cnt[1]), 64'(0));
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
